stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Two-digit BCD stopwatch: prescaled tick, IDLE/RUN/PAUSE control, 7-segment drive.
// Latency: tick_o/digits/ovf_o update on the wrapping edge; seg_lo/seg_hi lag the digits by 1 cycle.
// Backpressure: none; btn_* are single-cycle pulses consumed on the edge they are seen.
// Optional lap-hold feature is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter logic [31:0] TICK_DIV = 32'd10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
`ifdef STOPWATCH_LAP_EN
  input  logic       btn_lap,
  output logic       lap_o,
`endif
  output logic       tick_o,
  output logic [1:0] state_o,
  output logic [3:0] digit_lo,
  output logic [3:0] digit_hi,
  output logic [6:0] seg_lo,
  output logic [6:0] seg_hi,
  output logic       ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam logic [31:0] TICK_LAST = TICK_DIV - 32'd1;
  localparam logic [6:0]  SEG_ZERO  = 7'b1000000;

  state_t      state_q, state_d;
  logic [31:0] presc_q, presc_d;
  logic [3:0]  digit_lo_q, digit_lo_d;
  logic [3:0]  digit_hi_q, digit_hi_d;
  logic        tick_q, tick_d;
  logic        ovf_q, ovf_d;
  logic [6:0]  seg_lo_q, seg_lo_d;
  logic [6:0]  seg_hi_q, seg_hi_d;
  logic        run_stay;
  logic [3:0]  show_lo, show_hi;

  // Active-low {g,f,e,d,c,b,a}; undefined codes blank to the "0" pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  // Counting only happens when RUN is kept through this edge; a start/stop or
  // clear press freezes the prescaler so a would-be wrap produces no tick.
  assign run_stay = (state_q == ST_RUN) && !btn_ss && !btn_clr;

  // FSM next state: clear wins over start/stop.
  always_comb begin
    state_d = state_q;
    if (btn_clr) begin
      state_d = ST_IDLE;
    end else if (btn_ss) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Prescaler, BCD digits, tick and overflow pulses.
  always_comb begin
    presc_d    = presc_q;
    digit_lo_d = digit_lo_q;
    digit_hi_d = digit_hi_q;
    tick_d     = 1'b0;
    ovf_d      = 1'b0;
    if (btn_clr) begin
      presc_d    = 32'd0;
      digit_lo_d = 4'd0;
      digit_hi_d = 4'd0;
    end else if (run_stay) begin
      if (presc_q == TICK_LAST) begin
        presc_d = 32'd0;
        tick_d  = 1'b1;
        if (digit_lo_q == 4'd9) begin
          digit_lo_d = 4'd0;
          if (digit_hi_q == 4'd9) begin
            digit_hi_d = 4'd0;
            ovf_d      = 1'b1;
          end else begin
            digit_hi_d = digit_hi_q + 4'd1;
          end
        end else begin
          digit_lo_d = digit_lo_q + 4'd1;
        end
      end else begin
        presc_d = presc_q + 32'd1;
      end
    end else if (state_q == ST_IDLE) begin
      presc_d = 32'd0;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic       lap_q, lap_d;
  logic [3:0] lap_lo_q, lap_lo_d;
  logic [3:0] lap_hi_q, lap_hi_d;

  // Lap hold toggles only in RUN; entering hold snapshots the current digits.
  always_comb begin
    lap_d    = lap_q;
    lap_lo_d = lap_lo_q;
    lap_hi_d = lap_hi_q;
    if (btn_clr) begin
      lap_d = 1'b0;
    end else if (btn_lap && (state_q == ST_RUN)) begin
      lap_d = !lap_q;
      if (!lap_q) begin
        lap_lo_d = digit_lo_q;
        lap_hi_d = digit_hi_q;
      end
    end
  end

  // Lap state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_q    <= 1'b0;
      lap_lo_q <= 4'd0;
      lap_hi_q <= 4'd0;
    end else begin
      lap_q    <= lap_d;
      lap_lo_q <= lap_lo_d;
      lap_hi_q <= lap_hi_d;
    end
  end

  assign show_lo = lap_q ? lap_lo_q : digit_lo_q;
  assign show_hi = lap_q ? lap_hi_q : digit_hi_q;
  assign lap_o   = lap_q;
`else
  assign show_lo = digit_lo_q;
  assign show_hi = digit_hi_q;
`endif

  // Segment decode feeding the output registers (one cycle behind the digits).
  always_comb begin
    seg_lo_d = seg_decode(show_lo);
    seg_hi_d = seg_decode(show_hi);
  end

  // All state registers; reset discards any partial prescaler count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= 32'd0;
      digit_lo_q <= 4'd0;
      digit_hi_q <= 4'd0;
      tick_q     <= 1'b0;
      ovf_q      <= 1'b0;
      seg_lo_q   <= SEG_ZERO;
      seg_hi_q   <= SEG_ZERO;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      digit_lo_q <= digit_lo_d;
      digit_hi_q <= digit_hi_d;
      tick_q     <= tick_d;
      ovf_q      <= ovf_d;
      seg_lo_q   <= seg_lo_d;
      seg_hi_q   <= seg_hi_d;
    end
  end

  assign state_o  = state_q;
  assign tick_o   = tick_q;
  assign ovf_o    = ovf_q;
  assign digit_lo = digit_lo_q;
  assign digit_hi = digit_hi_q;
  assign seg_lo   = seg_lo_q;
  assign seg_hi   = seg_hi_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4.
// Expected values come from a vector table and a cycle-level reference model
// whose predictions are queued at drive time and popped after the edge.
module tb_stopwatch_ctrl;

  localparam int TDIV = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_clr = 1'b0;
  logic       tick_o;
  logic [1:0] state_o;
  logic [3:0] digit_lo, digit_hi;
  logic [6:0] seg_lo, seg_hi;
  logic       ovf_o;
`ifdef STOPWATCH_LAP_EN
  logic       btn_lap = 1'b0;
  logic       lap_o;
`endif

  stopwatch_ctrl #(.TICK_DIV(32'd4)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_ss   (btn_ss),
    .btn_clr  (btn_clr),
`ifdef STOPWATCH_LAP_EN
    .btn_lap  (btn_lap),
    .lap_o    (lap_o),
`endif
    .tick_o   (tick_o),
    .state_o  (state_o),
    .digit_lo (digit_lo),
    .digit_hi (digit_hi),
    .seg_lo   (seg_lo),
    .seg_hi   (seg_hi),
    .ovf_o    (ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic       tick;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       ovf;
    logic [6:0] sl;
    logic [6:0] sh;
    logic       lap;
  } exp_t;

  typedef struct {
    logic       ss;
    logic       clr;
    logic       r;
    logic [1:0] st;
    logic       tick;
    logic [3:0] lo;
    logic [6:0] sl;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vt[11];
  logic [6:0] seg_tab[10];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [1:0] m_st;
  int         m_pre, m_lo, m_hi, m_llo, m_lhi;
  logic       m_tick, m_ovf, m_lap;
  logic [6:0] m_sl, m_sh;

  function automatic logic [6:0] dec(input int d);
    if (d >= 0 && d <= 9) return seg_tab[d];
    return 7'b1000000;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic ss, input logic clr, input logic r, input logic lap);
    logic [1:0] o_st;
    int         o_lo, o_hi;
    logic       o_lap, stay;
    o_st = m_st; o_lo = m_lo; o_hi = m_hi; o_lap = m_lap;
    if (r) begin
      m_st = 2'b00; m_pre = 0; m_lo = 0; m_hi = 0; m_tick = 1'b0; m_ovf = 1'b0;
      m_sl = 7'b1000000; m_sh = 7'b1000000; m_lap = 1'b0; m_llo = 0; m_lhi = 0;
    end else begin
      m_sl = dec(o_lap ? m_llo : o_lo);
      m_sh = dec(o_lap ? m_lhi : o_hi);
      m_tick = 1'b0;
      m_ovf  = 1'b0;
      if (clr) begin
        m_st = 2'b00; m_pre = 0; m_lo = 0; m_hi = 0; m_lap = 1'b0;
      end else begin
        stay = (o_st == 2'b01) && !ss;
        if (stay) begin
          if (m_pre == TDIV - 1) begin
            m_pre  = 0;
            m_tick = 1'b1;
            m_lo   = m_lo + 1;
            if (m_lo == 10) begin
              m_lo = 0;
              m_hi = m_hi + 1;
              if (m_hi == 10) begin
                m_hi  = 0;
                m_ovf = 1'b1;
              end
            end
          end else begin
            m_pre = m_pre + 1;
          end
        end
        if (ss) m_st = (o_st == 2'b01) ? 2'b10 : 2'b01;
        if (LAP_EN && lap && o_st == 2'b01) begin
          m_lap = !o_lap;
          if (!o_lap) begin
            m_llo = o_lo;
            m_lhi = o_hi;
          end
        end
      end
    end
  endtask

  task automatic step(input logic ss, input logic clr, input logic r, input logic lap);
    exp_t e;
    btn_ss = ss; btn_clr = clr; rst = r;
`ifdef STOPWATCH_LAP_EN
    btn_lap = lap;
`endif
    model_step(ss, clr, r, lap);
    e.st = m_st; e.tick = m_tick; e.lo = 4'(m_lo); e.hi = 4'(m_hi);
    e.ovf = m_ovf; e.sl = m_sl; e.sh = m_sh; e.lap = m_lap;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("state", 8'(state_o), 8'(e.st));
    chk("tick", 8'(tick_o), 8'(e.tick));
    chk("digit_lo", 8'(digit_lo), 8'(e.lo));
    chk("digit_hi", 8'(digit_hi), 8'(e.hi));
    chk("ovf", 8'(ovf_o), 8'(e.ovf));
    chk("seg_lo", 8'(seg_lo), 8'(e.sl));
    chk("seg_hi", 8'(seg_hi), 8'(e.sh));
`ifdef STOPWATCH_LAP_EN
    chk("lap", 8'(lap_o), 8'(e.lap));
`endif
    btn_ss = 1'b0; btn_clr = 1'b0; rst = 1'b0;
`ifdef STOPWATCH_LAP_EN
    btn_lap = 1'b0;
`endif
  endtask

  // Advance idle cycles until the model reaches the wanted condition.
  task automatic run_until_digits(input string name, input int lo, input int hi);
    int n;
    n = 0;
    while (!(m_lo == lo && m_hi == hi) && n < 2000) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk({name, "_reached"}, 8'(m_lo == lo && m_hi == hi), 8'd1);
  endtask

  task automatic run_until_pre(input string name, input int pre);
    int n;
    n = 0;
    while (m_pre != pre && n < 20) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk({name, "_reached"}, 8'(m_pre == pre), 8'd1);
  endtask

  initial begin
    int ticks;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    //          ss    clr   rst   state  tick  lo    seg_lo
    vt[0]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 7'b1000000};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'd0, 7'b1000000};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'd0, 7'b1000000};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'd0, 7'b1000000};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'd0, 7'b1000000};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 4'd1, 7'b1000000};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'd1, 7'b1111001};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'd1, 7'b1111001};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'd1, 7'b1111001};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 4'd2, 7'b1111001};
    vt[10] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'd2, 7'b0100100};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      step(vt[i].ss, vt[i].clr, vt[i].r, 1'b0);
      chk("vec_state", 8'(state_o), 8'(vt[i].st));
      chk("vec_tick", 8'(tick_o), 8'(vt[i].tick));
      chk("vec_lo", 8'(digit_lo), 8'(vt[i].lo));
      chk("vec_seg_lo", 8'(seg_lo), 8'(vt[i].sl));
    end

    // 99 -> 00 wrap with a single-cycle overflow pulse, still running.
    run_until_digits("to99", 9, 9);
    run_until_pre("to99_pre", TDIV - 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_ovf", 8'(ovf_o), 8'd1);
    chk("wrap_digits", {digit_hi, digit_lo}, 8'h00);
    chk("wrap_state", 8'(state_o), 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_ovf_off", 8'(ovf_o), 8'd0);
    chk("wrap_state2", 8'(state_o), 8'd1);

    // Pause at prescaler 2, no ticks while paused, tick 2 cycles after resume.
    run_until_pre("pause_pre", 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (tick_o) ticks++;
    end
    chk("pause_no_tick", 8'(ticks), 8'd0);
    chk("pause_state", 8'(state_o), 8'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume_state", 8'(state_o), 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("resume_tick1", 8'(tick_o), 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("resume_tick2", 8'(tick_o), 8'd1);

    // Clear and start/stop together at 37: clear wins.
    run_until_digits("to37", 7, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("clr_state", 8'(state_o), 8'd0);
    chk("clr_digits", {digit_hi, digit_lo}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_seg_lo", 8'(seg_lo), 8'h40);
    chk("clr_seg_hi", 8'(seg_hi), 8'h40);

    // Reset mid-run exactly where the prescaler would wrap.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    run_until_pre("rst_pre", 3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_tick", 8'(tick_o), 8'd0);
    chk("rst_state", 8'(state_o), 8'd0);
    chk("rst_digits", {digit_hi, digit_lo}, 8'h00);
    chk("rst_seg_lo", 8'(seg_lo), 8'h40);
    chk("rst_seg_hi", 8'(seg_hi), 8'h40);
    chk("rst_ovf", 8'(ovf_o), 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_tick_after", 8'(tick_o), 8'd0);

`ifdef STOPWATCH_LAP_EN
    // Lap hold at 12 while the counters run on to 15.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_until_digits("to12", 2, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lap_on", 8'(lap_o), 8'd1);
    run_until_digits("to15", 5, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lap_seg_lo", 8'(seg_lo), 8'(seg_tab[2]));
    chk("lap_seg_hi", 8'(seg_hi), 8'(seg_tab[1]));
    chk("lap_live", {digit_hi, digit_lo}, 8'h15);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lap_off", 8'(lap_o), 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lap_release_seg", 8'(seg_lo), 8'(seg_tab[5]));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
